// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter:
// FSM state encoding and the port-select values.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of the
// unified memory arbiter, with arbiter-side and environment-side views.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // Requesters raise req and hold it with stable address/data until their
    // one-cycle ack; the arbiter holds mem_req with stable mem_* until mem_ack.
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-input round-robin arbiter: on a tie the port not granted last wins,
// a lone request wins outright. Purely combinational.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = GRANT_I;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports, one
// transaction at a time, with round-robin arbitration and an ack timeout.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    unified_mem_arbiter_if.slave  bus,
    output state_t                state
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t            state_q;
    logic              last_grant;
    logic              cur_grant;
    logic              grant;
    logic [TMR_W-1:0]  timer;
    logic [DATA_W-1:0] rdata_cap;
    logic              err_flag;

    logic              i_ack_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              err_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    arb_rr2 u_arb (
        .req        ({bus.d_req, bus.i_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_grant  <= GRANT_I;
            cur_grant   <= GRANT_I;
            timer       <= '0;
            rdata_cap   <= '0;
            err_flag    <= 1'b0;
            i_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    i_ack_q   <= 1'b0;
                    d_ack_q   <= 1'b0;
                    err_q     <= 1'b0;
                    i_rdata_q <= '0;
                    d_rdata_q <= '0;
                    // While an ack is visible the requester has not yet had a
                    // chance to drop req, so a still-high req is not a new one.
                    if (!(i_ack_q || d_ack_q) && (bus.i_req || bus.d_req)) begin
                        cur_grant <= grant;
                        mem_req_q <= 1'b1;
                        timer     <= '0;
                        err_flag  <= 1'b0;
                        state_q   <= WAIT;
                        if (grant == GRANT_D) begin
                            mem_addr_q  <= bus.d_addr;
                            mem_we_q    <= bus.d_we;
                            mem_wdata_q <= bus.d_wdata;
                        end else begin
                            mem_addr_q  <= bus.i_addr;
                            mem_we_q    <= 1'b0;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_ack) begin
                        rdata_cap <= mem_we_q ? '0 : bus.mem_rdata;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_flag  <= 1'b0;
                        state_q   <= RESP;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        rdata_cap <= '0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_flag  <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                RESP: begin
                    if (cur_grant == GRANT_D) begin
                        d_ack_q   <= 1'b1;
                        d_rdata_q <= rdata_cap;
                    end else begin
                        i_ack_q   <= 1'b1;
                        i_rdata_q <= rdata_cap;
                    end
                    err_q      <= err_flag;
                    last_grant <= cur_grant;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state         = state_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter: fetch, store/load,
// round-robin ties, timeout, ack at the timeout boundary and mid-flight reset.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    state_t state;
    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    logic [31:0] mem_model [0:255];

    // memory-responder snapshot of the request it served
    bit          s_ok;
    logic [7:0]  s_addr;
    logic        s_we;
    logic [31:0] s_wdata;

    // ack observation
    int          w_cycles;
    int          w_time;
    logic        w_iack, w_dack, w_err;
    logic [31:0] w_irdata, w_drdata;

    unified_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic mem_serve(input int lat);
        int guard;
        guard = 0;
        s_ok  = 1'b0;
        while (bus.mem_req !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (bus.mem_req !== 1'b1) return;
        s_ok    = 1'b1;
        s_addr  = bus.mem_addr;
        s_we    = bus.mem_we;
        s_wdata = bus.mem_wdata;
        if (lat == 0) return;
        for (int j = 1; j < lat; j++) @(negedge clk);
        bus.mem_ack = 1'b1;
        if (s_we) begin
            mem_model[s_addr] = s_wdata;
            bus.mem_rdata = 32'hA5A5_A5A5;
        end else begin
            bus.mem_rdata = mem_model[s_addr];
        end
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic wait_ack();
        w_cycles = -1;
        w_iack = 1'b0; w_dack = 1'b0; w_err = 1'b0;
        w_irdata = '0; w_drdata = '0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
                w_cycles = j;
                w_time   = cyc;
                w_iack   = bus.i_ack;
                w_dack   = bus.d_ack;
                w_err    = bus.err;
                w_irdata = bus.i_rdata;
                w_drdata = bus.d_rdata;
                break;
            end
        end
    endtask

    task automatic clear_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({bus.i_ack, bus.d_ack, bus.err, bus.mem_req, bus.mem_we} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                {bus.i_ack, bus.d_ack, bus.err, bus.mem_req, bus.mem_we});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 40'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got %h expected 0", {bus.mem_addr, bus.mem_wdata});
        end
        n_checks++;
        if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 0", {bus.i_rdata, bus.d_rdata});
        end
        n_checks++;
        if (state !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE);
        end
    endtask

    task automatic test_single_fetch();
        mem_model[8'h05] = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 8'h05; bus.d_wdata = 32'h1111_2222;
        mem_serve(2);
        n_checks++;
        if ({s_ok, s_addr, s_we, s_wdata} !== {1'b1, 8'h05, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL fetch_mem_bus: got ok=%b addr=%h we=%b wdata=%h expected ok=1 addr=05 we=0 wdata=0",
                s_ok, s_addr, s_we, s_wdata);
        end
        wait_ack();
        n_checks++;
        if (w_cycles !== 1) begin
            n_fail++; $display("FAIL fetch_ack_latency: got %0d expected 1", w_cycles);
        end
        n_checks++;
        if ({w_iack, w_dack, w_err} !== 3'b100) begin
            n_fail++; $display("FAIL fetch_ack_flags: got %b expected 100", {w_iack, w_dack, w_err});
        end
        n_checks++;
        if (w_irdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL fetch_rdata: got %h expected deadbeef", w_irdata);
        end
        bus.i_req = 1'b0; bus.d_wdata = '0;
        @(negedge clk);
        n_checks++;
        if ({bus.i_ack, bus.d_ack} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_ack_pulse: got %b expected 00", {bus.i_ack, bus.d_ack});
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h10; bus.d_wdata = 32'h1234_5678;
        mem_serve(1);
        n_checks++;
        if ({s_ok, s_addr, s_we, s_wdata} !== {1'b1, 8'h10, 1'b1, 32'h1234_5678}) begin
            n_fail++; $display("FAIL store_mem_bus: got ok=%b addr=%h we=%b wdata=%h expected ok=1 addr=10 we=1 wdata=12345678",
                s_ok, s_addr, s_we, s_wdata);
        end
        wait_ack();
        n_checks++;
        if ({w_iack, w_dack, w_err, w_drdata} !== {3'b010, 32'h0}) begin
            n_fail++; $display("FAIL store_ack: got flags=%b d_rdata=%h expected flags=010 d_rdata=0",
                {w_iack, w_dack, w_err}, w_drdata);
        end
        // req stays high: becomes the following load
        bus.d_we = 1'b0; bus.d_wdata = '0;
        mem_serve(1);
        n_checks++;
        if ({s_ok, s_addr, s_we} !== {1'b1, 8'h10, 1'b0}) begin
            n_fail++; $display("FAIL load_mem_bus: got ok=%b addr=%h we=%b expected ok=1 addr=10 we=0", s_ok, s_addr, s_we);
        end
        wait_ack();
        n_checks++;
        if ({w_dack, w_drdata} !== {1'b1, 32'h1234_5678}) begin
            n_fail++; $display("FAIL load_rdata: got ack=%b data=%h expected ack=1 data=12345678", w_dack, w_drdata);
        end
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie();
        int   prev_time;
        logic exp_d;
        mem_model[8'h20] = 32'hC0DE_0020;
        mem_model[8'h30] = 32'hDA7A_0030;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 8'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h30;
        prev_time = 0;
        for (int t = 0; t < 4; t++) begin
            exp_d = (t % 2 == 0);
            mem_serve(1);
            n_checks++;
            if (s_addr !== (exp_d ? 8'h30 : 8'h20)) begin
                n_fail++; $display("FAIL tie_grant_addr[%0d]: got %h expected %h", t, s_addr, exp_d ? 8'h30 : 8'h20);
            end
            wait_ack();
            n_checks++;
            if ({w_iack, w_dack} !== {~exp_d, exp_d}) begin
                n_fail++; $display("FAIL tie_ack_port[%0d]: got i=%b d=%b expected i=%b d=%b", t, w_iack, w_dack, ~exp_d, exp_d);
            end
            n_checks++;
            if ((exp_d ? w_drdata : w_irdata) !== (exp_d ? 32'hDA7A_0030 : 32'hC0DE_0020)) begin
                n_fail++; $display("FAIL tie_rdata[%0d]: got %h expected %h", t, exp_d ? w_drdata : w_irdata,
                    exp_d ? 32'hDA7A_0030 : 32'hC0DE_0020);
            end
            if (t > 0) begin
                n_checks++;
                if (w_time - prev_time !== 4) begin
                    n_fail++; $display("FAIL tie_spacing[%0d]: got %0d expected 4", t, w_time - prev_time);
                end
            end
            prev_time = w_time;
            if (t == 3) begin
                bus.i_req = 1'b0; bus.d_req = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if ({bus.i_ack, bus.d_ack} !== 2'b00) begin
                n_fail++; $display("FAIL tie_ack_pulse[%0d]: got %b expected 00", t, {bus.i_ack, bus.d_ack});
            end
        end
    endtask

    task automatic test_timeout();
        int guard;
        int n;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h40;
        guard = 0;
        while (bus.mem_req !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n = 0;
        while (bus.mem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n !== 15) begin
            n_fail++; $display("FAIL timeout_req_cycles: got %0d expected 15", n);
        end
        wait_ack();
        n_checks++;
        if ({w_cycles, w_iack, w_dack, w_err} !== {32'sd1, 3'b011}) begin
            n_fail++; $display("FAIL timeout_ack: got cycles=%0d flags=%b expected cycles=1 flags=011",
                w_cycles, {w_iack, w_dack, w_err});
        end
        n_checks++;
        if (w_drdata !== 32'h0) begin
            n_fail++; $display("FAIL timeout_rdata: got %h expected 0", w_drdata);
        end
        bus.d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err_pulse: got %b expected 0", bus.err);
        end
        bus.i_req = 1'b1; bus.i_addr = 8'h05;
        mem_serve(1);
        wait_ack();
        n_checks++;
        if ({w_iack, w_err, w_irdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL after_timeout_fetch: got ack=%b err=%b data=%h expected ack=1 err=0 data=deadbeef",
                w_iack, w_err, w_irdata);
        end
        bus.i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ack_boundary();
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 8'h20;
        mem_serve(15);
        wait_ack();
        n_checks++;
        if ({w_cycles, w_iack, w_err} !== {32'sd1, 2'b10}) begin
            n_fail++; $display("FAIL boundary_ack: got cycles=%0d ack=%b err=%b expected cycles=1 ack=1 err=0",
                w_cycles, w_iack, w_err);
        end
        n_checks++;
        if (w_irdata !== 32'hC0DE_0020) begin
            n_fail++; $display("FAIL boundary_rdata: got %h expected c0de0020", w_irdata);
        end
        bus.i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int   guard;
        logic stray;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h50; bus.d_wdata = 32'hFEED_F00D;
        guard = 0;
        while (bus.mem_req !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        bus.d_req = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 42'h0) begin
            n_fail++; $display("FAIL midreset_mem_bus: got req=%b we=%b addr=%h wdata=%h expected all 0",
                bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        n_checks++;
        if (state !== IDLE) begin
            n_fail++; $display("FAIL midreset_state: got %0d expected %0d", state, IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        stray = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (bus.i_ack || bus.d_ack || bus.err || bus.mem_req || state != IDLE) stray = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (stray !== 1'b0) begin
            n_fail++; $display("FAIL late_ack_ignored: got activity=%b expected 0", stray);
        end
        bus.i_req = 1'b1; bus.i_addr = 8'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h30;
        mem_serve(1);
        n_checks++;
        if ({s_ok, s_addr} !== {1'b1, 8'h30}) begin
            n_fail++; $display("FAIL post_reset_tie_addr: got ok=%b addr=%h expected ok=1 addr=30", s_ok, s_addr);
        end
        wait_ack();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        n_checks++;
        if ({w_iack, w_dack, w_drdata} !== {2'b01, 32'hDA7A_0030}) begin
            n_fail++; $display("FAIL post_reset_tie_ack: got i=%b d=%b data=%h expected i=0 d=1 data=da7a0030",
                w_iack, w_dack, w_drdata);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem_model[a] = 32'h0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_tie();
        test_timeout();
        test_ack_boundary();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
